// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: stall-reason codes, register
// index width, nominal pipeline latencies and the stall-reason priority encoder.
// No logic of its own; imported by the interface, the counter and the top.
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [1:0] stall_reason_t;

  localparam stall_reason_t STALL_NONE   = 2'd0;
  localparam stall_reason_t STALL_RAW    = 2'd1;
  localparam stall_reason_t STALL_WAW    = 2'd2;
  localparam stall_reason_t STALL_STRUCT = 2'd3;

  // Nominal result latencies of the fixed-latency units.
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MUL  = 3;

  // RAW outranks WAW outranks structural when several conflicts coincide.
  function automatic stall_reason_t stall_encode(input logic raw, input logic waw,
                                                 input logic strc);
    stall_reason_t r;
    r = STALL_NONE;
    if (raw)       r = STALL_RAW;
    else if (waw)  r = STALL_WAW;
    else if (strc) r = STALL_STRUCT;
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the ID stage and the hazard scoreboard.
// Carries the candidate instruction, flush, long-op completion and the stall results.
// master = ID/pipeline side (drives the request), slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 16
);
  import hazard_scoreboard_pkg::*;

  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rs1;
  logic [REG_IDX_W-1:0] issue_rs2;
  logic                 issue_rs1_used;
  logic                 issue_rs2_used;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 issue_reg_write;
  logic                 issue_long;
  logic [LAT_W-1:0]     issue_lat;
  logic                 flush;
  logic                 long_done;
  logic [REG_IDX_W-1:0] long_done_rd;

  logic                 stall;
  logic                 issue_fire;
  stall_reason_t        stall_reason;
  logic [NUM_REGS-1:0]  busy_mask;
  logic [CNT_W-1:0]     stall_cycles;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_reg_write, issue_long, issue_lat, flush,
           long_done, long_done_rd,
    input  stall, issue_fire, stall_reason, busy_mask, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used,
           issue_rd, issue_reg_write, issue_long, issue_lat, flush,
           long_done, long_done_rd,
    output stall, issue_fire, stall_reason, busy_mask, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register countdown of cycles until a pending result becomes bypassable.
// Latency: load/decrement take effect on the next clock; busy is flop-direct.
// No backpressure: load wins over the free-running decrement.
// Ports: clk, rst (async active-low), load/load_val (arm), cnt (current), busy (cnt!=0).
module sb_counter #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             busy
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = load_val;
    else if (cnt_q != '0)   cnt_d = cnt_q - LAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue hazard scoreboard: RAW/WAW/structural stall for ID from pending-write table.
// Latency: stall/issue_fire/stall_reason combinational; table and counter update next edge.
// Backpressure: stall holds IF/ID; flush only blocks issue and table updates.
// Ports: clk, rst (async active-low), sb (slave modport: issue request, flush,
//        long_done/long_done_rd in; stall, issue_fire, stall_reason, busy_mask, stall_cycles out).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_scoreboard_if.slave    sb
);

  logic                 long_pend_q, long_pend_d;
  logic [REG_IDX_W-1:0] long_rd_q,   long_rd_d;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;

  logic [LAT_W-1:0]     eff_lat;
  logic [LAT_W-1:0]     load_val;
  logic [LAT_W-1:0]     cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  cnt_busy;
  logic [NUM_REGS-1:0]  long_mask;

  logic raw, waw, strc, stall, issue_fire;
  logic long_done;
  logic [REG_IDX_W-1:0] long_done_rd;

  assign long_done    = sb.long_done;
  assign long_done_rd = sb.long_done_rd;

  assign eff_lat = (sb.issue_lat == '0) ? LAT_W'(1) : sb.issue_lat;
  // The issue cycle itself is the first tick of the countdown, so the stored
  // value is one less: lat=1 is never pending (next-cycle bypass), lat=L clears
  // L cycles after issue.
  assign load_val = eff_lat - LAT_W'(1);

  assign cnt[0]      = '0;
  assign cnt_busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic load;
    assign load = issue_fire & sb.issue_reg_write & ~sb.issue_long &
                  (sb.issue_rd == REG_IDX_W'(r));
    sb_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .cnt      (cnt[r]),
      .busy     (cnt_busy[r])
    );
  end

  // A long op whose completion is signalled this cycle is already bypassable,
  // so it no longer blocks consumers or same-rd writers in that cycle.
  function automatic logic long_hit(input logic [REG_IDX_W-1:0] r);
    return (r != '0) & long_pend_q & (long_rd_q == r) &
           ~(long_done & (long_done_rd == r));
  endfunction

  function automatic logic raw_pend(input logic [REG_IDX_W-1:0] r);
    return (r != '0) & (cnt_busy[r] | long_hit(r));
  endfunction

  always_comb begin
    raw = sb.issue_valid &
          ((sb.issue_rs1_used & raw_pend(sb.issue_rs1)) |
           (sb.issue_rs2_used & raw_pend(sb.issue_rs2)));
    // A younger fixed-latency write must not land before an older one to rd.
    waw = sb.issue_valid & sb.issue_reg_write & (sb.issue_rd != '0) &
          (long_hit(sb.issue_rd) | (~sb.issue_long & (cnt[sb.issue_rd] > eff_lat)));
    strc = sb.issue_valid & sb.issue_long & long_pend_q & ~long_done;
    stall      = raw | waw | strc;
    issue_fire = sb.issue_valid & ~stall & ~sb.flush;
  end

  always_comb begin
    long_pend_d = long_pend_q;
    long_rd_d   = long_rd_q;
    if (long_done) long_pend_d = 1'b0;
    // New long issue in the completion cycle keeps the unit occupied.
    if (issue_fire & sb.issue_long) begin
      long_pend_d = 1'b1;
      long_rd_d   = sb.issue_rd;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall & ~(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      long_pend_q    <= 1'b0;
      long_rd_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      long_pend_q    <= long_pend_d;
      long_rd_q      <= long_rd_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign long_mask = long_pend_q ? (NUM_REGS'(1) << long_rd_q) : '0;

  assign sb.stall        = stall;
  assign sb.issue_fire   = issue_fire;
  assign sb.stall_reason = stall_encode(raw, waw, strc);
  assign sb.busy_mask    = (cnt_busy | long_mask) & ~NUM_REGS'(1);
  assign sb.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an absolute-time reference model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  hazard_scoreboard_if bus ();

  hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // ready_t[r]: absolute cycle at which r's fixed-latency result is bypassable.
  int now = 0;
  int ready_t [32];
  bit lp  = 1'b0;
  int lrd = 0;
  int sc  = 0;

  function automatic int eff(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic bit long_hit(input int r);
    return r != 0 && lp && lrd == r && !(bus.long_done && int'(bus.long_done_rd) == r);
  endfunction

  function automatic bit src_pend(input int r);
    return r != 0 && (ready_t[r] > now || long_hit(r));
  endfunction

  function automatic bit m_raw();
    return bus.issue_valid &&
           ((bus.issue_rs1_used && src_pend(int'(bus.issue_rs1))) ||
            (bus.issue_rs2_used && src_pend(int'(bus.issue_rs2))));
  endfunction

  function automatic bit m_waw();
    int rd;
    rd = int'(bus.issue_rd);
    return bus.issue_valid && bus.issue_reg_write && rd != 0 &&
           (long_hit(rd) ||
            (!bus.issue_long && (ready_t[rd] - now) > eff(int'(bus.issue_lat))));
  endfunction

  function automatic bit m_struct();
    return bus.issue_valid && bus.issue_long && lp && !bus.long_done;
  endfunction

  function automatic bit m_stall();
    return m_raw() || m_waw() || m_struct();
  endfunction

  function automatic int m_reason();
    if (m_raw())    return 1;
    if (m_waw())    return 2;
    if (m_struct()) return 3;
    return 0;
  endfunction

  function automatic bit m_fire();
    return bus.issue_valid && !m_stall() && !bus.flush;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = (ready_t[r] > now) || (lp && lrd == r);
    return m;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 32; r++) ready_t[r] <= 0;
      lp  <= 1'b0;
      lrd <= 0;
      sc  <= 0;
      now <= 0;
    end else begin
      if (m_fire() && bus.issue_reg_write && bus.issue_rd != 0 && !bus.issue_long)
        ready_t[bus.issue_rd] <= now + eff(int'(bus.issue_lat));
      if (bus.long_done) lp <= 1'b0;
      if (m_fire() && bus.issue_long) begin
        lp  <= 1'b1;
        lrd <= int'(bus.issue_rd);
      end
      if (m_stall() && sc < 65535) sc <= sc + 1;
      now <= now + 1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("cmp_stall",        32'(bus.stall),        32'(m_stall()));
      chk("cmp_issue_fire",   32'(bus.issue_fire),   32'(m_fire()));
      chk("cmp_stall_reason", 32'(bus.stall_reason), 32'(m_reason()));
      chk("cmp_busy_mask",    bus.busy_mask,         m_busy());
      chk("cmp_stall_cycles", 32'(bus.stall_cycles), 32'(sc));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.issue_valid     = 1'b0;
    bus.issue_rs1       = '0;
    bus.issue_rs2       = '0;
    bus.issue_rs1_used  = 1'b0;
    bus.issue_rs2_used  = 1'b0;
    bus.issue_rd        = '0;
    bus.issue_reg_write = 1'b0;
    bus.issue_long      = 1'b0;
    bus.issue_lat       = '0;
    bus.flush           = 1'b0;
    bus.long_done       = 1'b0;
    bus.long_done_rd    = '0;
  endtask

  task automatic op(input int rs1, input bit u1, input int rs2, input bit u2,
                    input int rd, input bit wr, input bit lng, input int lat);
    idle();
    bus.issue_valid     = 1'b1;
    bus.issue_rs1       = 5'(rs1);
    bus.issue_rs1_used  = u1;
    bus.issue_rs2       = 5'(rs2);
    bus.issue_rs2_used  = u2;
    bus.issue_rd        = 5'(rd);
    bus.issue_reg_write = wr;
    bus.issue_long      = lng;
    bus.issue_lat       = 3'(lat);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #12;
    chk("rst_stall",        32'(bus.stall),        32'd0);
    chk("rst_fire",         32'(bus.issue_fire),   32'd0);
    chk("rst_reason",       32'(bus.stall_reason), 32'd0);
    chk("rst_busy",         bus.busy_mask,         32'd0);
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    @(posedge clk); #2; rst = 1'b1;

    // RAW on a fixed-latency producer: x3 lat=2
    op(0, 0, 0, 0, 3, 1, 0, LAT_LOAD);
    @(negedge clk); chk("raw_prod_fire", 32'(bus.issue_fire), 32'd1);
    tick();
    op(3, 1, 0, 0, 9, 1, 0, LAT_ALU);
    @(negedge clk);
    chk("raw_stall",  32'(bus.stall),        32'd1);
    chk("raw_reason", 32'(bus.stall_reason), 32'd1);
    chk("raw_busy3",  32'(bus.busy_mask[3]), 32'd1);
    tick();
    @(negedge clk);
    chk("raw_fire",      32'(bus.issue_fire),   32'd1);
    chk("raw_busy3_clr", 32'(bus.busy_mask[3]), 32'd0);
    tick(); idle();

    // WAW: x4 lat=3 then x4 lat=1
    op(0, 0, 0, 0, 4, 1, 0, LAT_MUL); tick();
    op(0, 0, 0, 0, 4, 1, 0, 1);
    @(negedge clk);
    chk("waw_stall",  32'(bus.stall),        32'd1);
    chk("waw_reason", 32'(bus.stall_reason), 32'd2);
    tick();
    @(negedge clk); chk("waw_fire", 32'(bus.issue_fire), 32'd1);
    tick(); idle();

    // RAW on a long op x7, released by long_done
    op(0, 0, 0, 0, 7, 1, 1, 0); tick();
    op(0, 0, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("lraw_stall",  32'(bus.stall),        32'd1);
    chk("lraw_reason", 32'(bus.stall_reason), 32'd1);
    chk("lraw_busy7",  32'(bus.busy_mask[7]), 32'd1);
    tick();
    @(negedge clk); chk("lraw_stall2", 32'(bus.stall), 32'd1);
    tick();
    bus.long_done = 1'b1; bus.long_done_rd = 5'd7;
    @(negedge clk); chk("lraw_fire", 32'(bus.issue_fire), 32'd1);
    tick(); idle();
    @(negedge clk); chk("lraw_busy7_clr", 32'(bus.busy_mask[7]), 32'd0);
    tick();

    // Structural: second long op while first in flight
    op(0, 0, 0, 0, 10, 1, 1, 0); tick();
    op(0, 0, 0, 0, 11, 1, 1, 0);
    @(negedge clk);
    chk("st_stall",  32'(bus.stall),        32'd1);
    chk("st_reason", 32'(bus.stall_reason), 32'd3);
    tick();
    bus.long_done = 1'b1; bus.long_done_rd = 5'd10;
    @(negedge clk); chk("st_fire", 32'(bus.issue_fire), 32'd1);
    tick(); idle();
    @(negedge clk);
    chk("st_busy11", 32'(bus.busy_mask[11]), 32'd1);
    chk("st_busy10", 32'(bus.busy_mask[10]), 32'd0);
    tick();
    bus.long_done = 1'b1; bus.long_done_rd = 5'd11;
    tick(); idle();
    @(negedge clk); chk("st_busy_empty", bus.busy_mask, 32'd0);
    tick();

    // x0 is never tracked, even with lat=7 or as a long destination
    op(0, 1, 0, 1, 0, 1, 0, 7);
    @(negedge clk); chk("x0_fire", 32'(bus.issue_fire), 32'd1);
    tick();
    @(negedge clk);
    chk("x0_stall", 32'(bus.stall), 32'd0);
    chk("x0_busy",  bus.busy_mask,  32'd0);
    tick();
    op(0, 0, 0, 0, 0, 1, 1, 0); tick();
    op(0, 1, 0, 1, 0, 1, 0, 0);
    @(negedge clk); chk("x0_long_nostall", 32'(bus.stall), 32'd0);
    tick();
    idle(); bus.long_done = 1'b1; bus.long_done_rd = 5'd0; tick(); idle();

    // Flush with a RAW hazard: no fire, no table update
    op(0, 0, 0, 0, 12, 1, 0, LAT_MUL); tick();
    op(12, 1, 0, 0, 13, 1, 0, 5); bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_stall",  32'(bus.stall),        32'd1);
    chk("fl_fire",   32'(bus.issue_fire),   32'd0);
    chk("fl_reason", 32'(bus.stall_reason), 32'd1);
    tick();
    op(0, 0, 0, 0, 14, 1, 0, 2); bus.flush = 1'b1;
    @(negedge clk);
    chk("fl_busy13", 32'(bus.busy_mask[13]), 32'd0);
    chk("fl_busy12", 32'(bus.busy_mask[12]), 32'd1);
    chk("fl_fire2",  32'(bus.issue_fire),    32'd0);
    tick(); idle();
    @(negedge clk); chk("fl_busy14", 32'(bus.busy_mask[14]), 32'd0);
    tick();

    // Reset with x5 counting (2 left) and a long op to x20 in flight
    op(0, 0, 0, 0, 20, 1, 1, 0); tick();
    op(0, 0, 0, 0, 5, 1, 0, 3); tick(); idle();
    @(negedge clk);
    chk("mr_pre_busy5",  32'(bus.busy_mask[5]),  32'd1);
    chk("mr_pre_busy20", 32'(bus.busy_mask[20]), 32'd1);
    #2; rst = 1'b0;
    #1;
    chk("mr_stall",        32'(bus.stall),        32'd0);
    chk("mr_fire",         32'(bus.issue_fire),   32'd0);
    chk("mr_reason",       32'(bus.stall_reason), 32'd0);
    chk("mr_busy",         bus.busy_mask,         32'd0);
    chk("mr_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    @(posedge clk); #2; rst = 1'b1;
    op(5, 1, 20, 1, 6, 1, 0, 1);
    @(negedge clk);
    chk("mr_post_fire",  32'(bus.issue_fire), 32'd1);
    chk("mr_post_stall", 32'(bus.stall),      32'd0);
    tick(); idle();

    // Stall counter saturation on a held structural stall
    op(0, 0, 0, 0, 21, 1, 1, 0); tick();
    op(0, 0, 0, 0, 22, 1, 1, 0);
    @(negedge clk); chk("sat_cnt0", 32'(bus.stall_cycles), 32'd0);
    repeat (10) tick();
    @(negedge clk); chk("sat_cnt10", 32'(bus.stall_cycles), 32'd10);
    repeat (65530) tick();
    @(negedge clk);
    chk("sat_max",   32'(bus.stall_cycles), 32'h0000_FFFF);
    chk("sat_stall", 32'(bus.stall),        32'd1);
    repeat (3) tick();
    @(negedge clk); chk("sat_hold", 32'(bus.stall_cycles), 32'h0000_FFFF);
    tick(); idle();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
